// File: rtl/dsp38_arb_pkg.sv
// dsp38_arb_pkg: shared widths, DSP feedback base and operand bundle for the DSP38 arbiter
package dsp38_arb_pkg;
   localparam int A_W = 20;
   localparam int B_W = 18;
   localparam int Z_W = 38;
   localparam logic [2:0] FB_BASE = 3'b100;
   typedef struct packed {
      logic [A_W-1:0] a;
      logic [B_W-1:0] b;
      logic [5:0]     shift;
      logic [1:0]     sel;
      logic           sub;
   } op_t;
endpackage

// File: rtl/dsp38.sv
// dsp38: combinational model of the DSP38 multiply-add-sub path (accumulator, rounding and saturation tied off)
module dsp38 #(
   parameter logic [19:0] COEFF_0 = 20'h00000,
   parameter logic [19:0] COEFF_1 = 20'h00000,
   parameter logic [19:0] COEFF_2 = 20'h00000,
   parameter logic [19:0] COEFF_3 = 20'h00000
) (
   input  logic [19:0] a,
   input  logic [17:0] b,
   input  logic [5:0]  acc_fir,
   input  logic [2:0]  feedback,
   input  logic        subtract,
   input  logic        unsigned_a,
   input  logic        unsigned_b,
   output logic [37:0] z
);
   logic [19:0] coeff, mul_a;
   logic [37:0] mul_a_x, mul_b_x, acc;
   // feedback[2] routes a coefficient into the multiplier while A feeds the shifted adder input
   always_comb begin
      coeff = feedback[1:0] == 2'd0 ? COEFF_0 : feedback[1:0] == 2'd1 ? COEFF_1 : feedback[1:0] == 2'd2 ? COEFF_2 : COEFF_3;
      mul_a = feedback[2] ? coeff : a;
      mul_a_x = unsigned_a ? {18'b0, mul_a} : {{18{mul_a[19]}}, mul_a};
      mul_b_x = unsigned_b ? {20'b0, b} : {{20{b[17]}}, b};
      acc = (unsigned_a ? {18'b0, a} : {{18{a[19]}}, a}) << acc_fir;
      z = subtract ? acc - mul_a_x * mul_b_x : acc + mul_a_x * mul_b_x;
   end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant searching upward from ptr with wrap
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_id
);
   logic [ID_W-1:0] idx;
   // walk from lowest to highest priority so the closest requester to ptr wins last
   always_comb begin
      gnt = '0;
      gnt_id = '0;
      idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = ID_W'((int'(ptr) + k) % NUM_REQ);
         if (en && req[idx]) begin
            gnt = '0;
            gnt[idx] = 1'b1;
            gnt_id = idx;
         end
      end
   end
endmodule

// File: rtl/dsp38_addsub_arbiter.sv
// dsp38_addsub_arbiter: round-robin sharing of one DSP38 (Z = (A<<shift) +/- COEFF[sel]*B); DSP_ARB_SAT_EN clamps the result
module dsp38_addsub_arbiter
   import dsp38_arb_pkg::*;
#(
   parameter int          NUM_REQ = 4,
   parameter int          ID_W    = 2,
   parameter logic [19:0] COEFF_0 = 20'h00000,
   parameter logic [19:0] COEFF_1 = 20'h00000,
   parameter logic [19:0] COEFF_2 = 20'h00010,
   parameter logic [19:0] COEFF_3 = 20'h00000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*A_W-1:0] req_a,
   input  logic [NUM_REQ*B_W-1:0] req_b,
   input  logic [NUM_REQ*6-1:0]   req_shift,
   input  logic [NUM_REQ*2-1:0]   req_sel,
   input  logic [NUM_REQ-1:0]     req_sub,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [Z_W-1:0]         rsp_z,
   output logic [ID_W-1:0]        rsp_id,
   output logic                   busy
);
   logic            adv, hs, op_v;
   logic [ID_W-1:0] rr_ptr, gnt_id, op_id;
   op_t             op, pick;
   logic [Z_W-1:0]  dsp_z, z_next;

   assign adv = !rsp_valid | rsp_ready;
   assign hs = |(req_valid & req_ready);
   assign busy = op_v | rsp_valid;
   assign pick = '{a: req_a[A_W*gnt_id +: A_W], b: req_b[B_W*gnt_id +: B_W], shift: req_shift[6*gnt_id +: 6], sel: req_sel[2*gnt_id +: 2], sub: req_sub[gnt_id]};

   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
      .req(req_valid), .ptr(rr_ptr), .en(reset & (!op_v | adv)), .gnt(req_ready), .gnt_id(gnt_id)
   );

   dsp38 #(.COEFF_0(COEFF_0), .COEFF_1(COEFF_1), .COEFF_2(COEFF_2), .COEFF_3(COEFF_3)) u_dsp (
      .a(op.a), .b(op.b), .acc_fir(op.shift), .feedback(FB_BASE | {1'b0, op.sel}), .subtract(op.sub),
      .unsigned_a(1'b1), .unsigned_b(1'b1), .z(dsp_z)
   );

`ifdef DSP_ARB_SAT_EN
   logic [A_W-1:0] coeff;
   logic [Z_W-1:0] a_sh, prod;
   logic [Z_W:0]   ref_sum;
   // a 39-bit copy of the DSP arithmetic exposes the carry/borrow used to clamp
   always_comb begin
      coeff = op.sel == 2'd0 ? COEFF_0 : op.sel == 2'd1 ? COEFF_1 : op.sel == 2'd2 ? COEFF_2 : COEFF_3;
      a_sh = {{(Z_W-A_W){1'b0}}, op.a} << op.shift;
      prod = {{(Z_W-A_W){1'b0}}, coeff} * {{(Z_W-B_W){1'b0}}, op.b};
      ref_sum = op.sub ? {1'b0, a_sh} - {1'b0, prod} : {1'b0, a_sh} + {1'b0, prod};
      z_next = ref_sum[Z_W] ? (op.sub ? '0 : '1) : dsp_z;
   end
`else
   assign z_next = dsp_z;
`endif

   // operand stage S1, result stage S2 and round-robin pointer
   always_ff @(posedge clk) begin
      if (!reset) begin
         op_v <= 1'b0;
         op <= '0;
         op_id <= '0;
         rr_ptr <= '0;
         rsp_valid <= 1'b0;
         rsp_z <= '0;
         rsp_id <= '0;
      end else begin
         if (adv) begin
            rsp_valid <= op_v;
            if (op_v) begin
               rsp_z <= z_next;
               rsp_id <= op_id;
            end
         end
         if (hs) begin
            op <= pick;
            op_id <= gnt_id;
            op_v <= 1'b1;
            rr_ptr <= gnt_id == ID_W'(NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
         end else begin
            op_v <= op_v & !adv;
         end
      end
   end
endmodule

// File: tb/tb_dsp38_addsub_arbiter.sv
// tb_dsp38_addsub_arbiter: scoreboard bench with a behavioural arbiter/arithmetic model
module tb_dsp38_addsub_arbiter;
   localparam int N = 4;
   localparam int IDW = 2;
   localparam logic [19:0] C0 = 20'h12345;
   localparam logic [19:0] C1 = 20'hABCDE;
   localparam logic [19:0] C2 = 20'h00010;
   localparam logic [19:0] C3 = 20'h00001;

   logic            clk, reset, rsp_valid, rsp_ready, busy;
   logic [N-1:0]    req_valid, req_ready, req_sub;
   logic [N*20-1:0] req_a;
   logic [N*18-1:0] req_b;
   logic [N*6-1:0]  req_shift;
   logic [N*2-1:0]  req_sel;
   logic [37:0]     rsp_z;
   logic [IDW-1:0]  rsp_id;

   dsp38_addsub_arbiter #(.NUM_REQ(N), .ID_W(IDW), .COEFF_0(C0), .COEFF_1(C1), .COEFF_2(C2), .COEFF_3(C3)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .req_shift(req_shift), .req_sel(req_sel), .req_sub(req_sub), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_z(rsp_z), .rsp_id(rsp_id), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [IDW-1:0] id;
      logic [37:0]    z;
      int             issue;
   } ent_t;

   ent_t           q[$];
   ent_t           e;
   int             tests = 0, fails = 0, cyc = 0, npop = 0, npush = 0, mptr = 0, sz;
   int             gcnt[N];
   bit             mon_en = 0, can, exp_rv;
   logic [N-1:0]   exp_gnt;
   logic [IDW-1:0] gi;
   logic [37:0]    last_z, hold_z;
   logic [IDW-1:0] last_id, hold_id;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   function automatic logic [37:0] model(input logic [19:0] a, input logic [17:0] b, input logic [5:0] sh,
                                         input logic [1:0] sel, input logic sub);
      logic [127:0] w;
      logic [63:0]  as, p, r;
      logic [19:0]  c;
      c = sel == 2'd0 ? C0 : sel == 2'd1 ? C1 : sel == 2'd2 ? C2 : C3;
      w = {108'b0, a} << sh;
      as = {26'b0, w[37:0]};
      p = {44'b0, c} * {46'b0, b};
      r = sub ? as - p : as + p;
`ifdef DSP_ARB_SAT_EN
      if (!sub && r > 64'h3F_FFFF_FFFF) r = 64'h3F_FFFF_FFFF;
      if (sub && p > as) r = 64'd0;
`endif
      return r[37:0];
   endfunction

   // monitor: predicts the grant and occupancy, pops results, pushes issued ops
   always @(negedge clk) begin
      if (mon_en) begin
         sz = q.size();
         can = !(sz == 2 && !rsp_ready);
         exp_gnt = '0;
         for (int k = 0; k < N; k++) begin
            gi = IDW'((mptr + k) % N);
            if (can && exp_gnt == '0 && req_valid[gi]) exp_gnt[gi] = 1'b1;
         end
         exp_rv = sz > 0 && q[0].issue < cyc;
         check("req_ready", 64'(req_ready), 64'(exp_gnt));
         check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
         check("busy", 64'(busy), 64'(sz > 0));
         if (rsp_valid && rsp_ready && sz > 0) begin
            check("rsp_z", 64'(rsp_z), 64'(q[0].z));
            check("rsp_id", 64'(rsp_id), 64'(q[0].id));
            last_z = rsp_z;
            last_id = rsp_id;
            npop++;
            void'(q.pop_front());
         end
         for (int g = 0; g < N; g++) begin
            if (exp_gnt[g]) begin
               e.id = IDW'(g);
               e.z = model(req_a[20*g +: 20], req_b[18*g +: 18], req_shift[6*g +: 6], req_sel[2*g +: 2], req_sub[g]);
               e.issue = cyc + 1;
               q.push_back(e);
               gcnt[g]++;
               npush++;
               mptr = (g + 1) % N;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [19:0] a, input logic [17:0] b, input logic [5:0] sh,
                          input logic [1:0] sel, input logic sub);
      req_a[20*i +: 20] = a;
      req_b[18*i +: 18] = b;
      req_shift[6*i +: 6] = sh;
      req_sel[2*i +: 2] = sel;
      req_sub[i] = sub;
   endtask

   task automatic rand_all();
      for (int i = 0; i < N; i++)
         set_req(i, ($urandom % 8 == 0) ? 20'hFFFFF : 20'($urandom), 18'($urandom), 6'($urandom_range(0, 40)),
                 2'($urandom), 1'($urandom));
   endtask

   task automatic wait_pops(input string nm, input int n, input int bound);
      int target;
      bit ok;
      target = npop + n;
      ok = 0;
      for (int c = 0; c < bound && !ok; c++) begin
         @(negedge clk);
         #1;
         ok = npop >= target;
      end
      check({nm, "_done"}, 64'(ok), 64'd1);
   endtask

   task automatic wait_empty(input string nm, input int bound);
      bit ok;
      ok = q.size() == 0;
      for (int c = 0; c < bound && !ok; c++) begin
         @(negedge clk);
         #1;
         ok = q.size() == 0;
      end
      check({nm, "_drain"}, 64'(ok), 64'd1);
   endtask

   initial begin
      reset = 1'b0;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      req_shift = '0;
      req_sel = '0;
      req_sub = '0;
      rsp_ready = 1'b1;
      foreach (gcnt[i]) gcnt[i] = 0;
      repeat (2) step();
      @(negedge clk);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_z", 64'(rsp_z), 64'd0);
      check("rst_rsp_id", 64'(rsp_id), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      step();
      reset = 1'b1;
      mptr = 0;
      mon_en = 1'b1;
      // single request with the known subtract result
      set_req(0, 20'h00100, 18'd2, 6'd4, 2'd2, 1'b1);
      req_valid = 4'b0001;
      step();
      req_valid = '0;
      wait_pops("t1", 1, 10);
      check("t1_z", 64'(last_z), 64'h0FE0);
      check("t1_id", 64'(last_id), 64'd0);
      // all requesters continuously valid
      step();
      rand_all();
      foreach (gcnt[i]) gcnt[i] = 0;
      req_valid = '1;
      repeat (12) step();
      req_valid = '0;
      wait_empty("t2", 10);
      for (int i = 0; i < N; i++) check("t2_fair", 64'(gcnt[i]), 64'd3);
      // backpressure with both stages full
      step();
      rand_all();
      rsp_ready = 1'b0;
      req_valid = '1;
      step();
      step();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         if (i == 0) begin
            hold_z = rsp_z;
            hold_id = rsp_id;
         end else begin
            check("t3_z_stable", 64'(rsp_z), 64'(hold_z));
            check("t3_id_stable", 64'(rsp_id), 64'(hold_id));
         end
         check("t3_no_grant", 64'(req_ready), 64'd0);
      end
      step();
      rsp_ready = 1'b1;
      req_valid = '0;
      wait_pops("t3", 2, 10);
      check("t3_empty", 64'(q.size()), 64'd0);
      // wrap/clamp boundaries
      step();
      set_req(2, 20'hFFFFF, 18'd1, 6'd63, 2'd3, 1'b0);
      req_valid = 4'b0100;
      step();
      req_valid = '0;
      wait_pops("t4", 1, 10);
      check("t4_z", 64'(last_z), 64'd1);
      check("t4_id", 64'(last_id), 64'd2);
      step();
      set_req(1, 20'hFFFFF, 18'd3, 6'd18, 2'd1, 1'b0);
      set_req(3, 20'h00000, 18'd5, 6'd0, 2'd1, 1'b1);
      req_valid = 4'b1010;
      step();
      step();
      req_valid = '0;
      wait_empty("t4b", 10);
      // reset with S1 and S2 full
      step();
      rand_all();
      rsp_ready = 1'b0;
      req_valid = '1;
      step();
      step();
      mon_en = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      check("t5_busy_before", 64'(busy), 64'd1);
      check("t5_ready_in_rst", 64'(req_ready), 64'd0);
      step();
      reset = 1'b1;
      req_valid = '0;
      @(negedge clk);
      check("t5_rsp_valid", 64'(rsp_valid), 64'd0);
      check("t5_rsp_z", 64'(rsp_z), 64'd0);
      check("t5_rsp_id", 64'(rsp_id), 64'd0);
      check("t5_busy", 64'(busy), 64'd0);
      check("t5_req_ready", 64'(req_ready), 64'd0);
      step();
      q.delete();
      mptr = 0;
      rsp_ready = 1'b1;
      req_valid = '1;
      mon_en = 1'b1;
      step();
      req_valid = '0;
      wait_empty("t5", 10);
      // random traffic with random backpressure
      begin
         int start;
         start = npush;
         for (int c = 0; c < 60000 && npush - start < 10000; c++) begin
            step();
            rand_all();
            req_valid = N'($urandom);
            rsp_ready = ($urandom % 4) != 0;
         end
         step();
         req_valid = '0;
         rsp_ready = 1'b1;
         wait_empty("t6", 10);
         check("t6_ops", 64'(npush - start >= 10000), 64'd1);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
